// File: rtl/epw22_cpu.sv
// 16-bit single-issue register-machine core: 8 registers, one instruction at a
// time over valid/ready, result write-back port and a synchronous data-memory port.
module epw22_cpu #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        result_reg,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, HALT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] result_q, mem_addr_q, mem_wdata_q;
    logic [2:0]        result_reg_q, ld_rd_q;
    logic [3:0]        flags_q;
    logic              result_valid_q, mem_we_q, halted_q;

    logic [3:0]        op;
    logic [2:0]        rd;
    logic [DATA_W-1:0] a, b, res_d;
    logic [DATA_W:0]   wide_d;
    logic              c_d, v_d, wr_d, set_flags_d;

    assign op = instr[15:12];
    assign rd = instr[11:9];
    assign a  = regs_q[instr[8:6]];
    assign b  = regs_q[instr[5:3]];

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both 1; instr_ready is high only in IDLE and never in reset.
    assign instr_ready  = (state_q == IDLE) && !reset;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign result_reg   = result_reg_q;
    assign flags        = flags_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign halted       = halted_q;
    assign dbg_state    = state_q;

    always_comb begin
        res_d       = '0;
        wide_d      = '0;
        c_d         = 1'b0;
        v_d         = 1'b0;
        wr_d        = 1'b0;
        set_flags_d = 1'b0;
        case (op)
            4'h1, 4'hD: begin
                wide_d      = {1'b0, a} + ((op == 4'h1) ? {1'b0, b} : (DATA_W+1)'(1));
                res_d       = wide_d[DATA_W-1:0];
                c_d         = wide_d[DATA_W];
                v_d         = !a[DATA_W-1] && res_d[DATA_W-1];
                if (op == 4'h1)
                    v_d = (a[DATA_W-1] == b[DATA_W-1]) && (res_d[DATA_W-1] != a[DATA_W-1]);
                wr_d        = 1'b1;
                set_flags_d = 1'b1;
            end
            4'h2, 4'hE: begin
                // Bit DATA_W of the widened difference is the unsigned borrow.
                wide_d      = {1'b0, a} - {1'b0, b};
                res_d       = wide_d[DATA_W-1:0];
                c_d         = wide_d[DATA_W];
                v_d         = (a[DATA_W-1] != b[DATA_W-1]) && (res_d[DATA_W-1] != a[DATA_W-1]);
                wr_d        = (op == 4'h2);
                set_flags_d = 1'b1;
            end
            4'h3: begin res_d = a & b;       wr_d = 1'b1; set_flags_d = 1'b1; end
            4'h4: begin res_d = a | b;       wr_d = 1'b1; set_flags_d = 1'b1; end
            4'h5: begin res_d = a ^ b;       wr_d = 1'b1; set_flags_d = 1'b1; end
            4'h6: begin res_d = a << b[3:0]; wr_d = 1'b1; set_flags_d = 1'b1; end
            4'h7: begin res_d = a >> b[3:0]; wr_d = 1'b1; set_flags_d = 1'b1; end
            4'hC: begin res_d = ~a;          wr_d = 1'b1; set_flags_d = 1'b1; end
            4'h8: begin res_d = {{(DATA_W-9){instr[8]}}, instr[8:0]}; wr_d = 1'b1; end
            4'hB: begin res_d = a;           wr_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            result_q       <= '0;
            result_reg_q   <= '0;
            result_valid_q <= 1'b0;
            flags_q        <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_we_q       <= 1'b0;
            halted_q       <= 1'b0;
            ld_rd_q        <= '0;
        end else begin
            result_valid_q <= 1'b0;
            mem_we_q       <= 1'b0;
            case (state_q)
                IDLE: if (instr_valid) begin
                    if (wr_d) begin
                        regs_q[rd]     <= res_d;
                        result_q       <= res_d;
                        result_reg_q   <= rd;
                        result_valid_q <= 1'b1;
                    end
                    if (set_flags_d)
                        flags_q <= {res_d == '0, res_d[DATA_W-1], c_d, v_d};
                    case (op)
                        4'h9: begin
                            mem_addr_q <= a;
                            ld_rd_q    <= rd;
                            state_q    <= MEM_RD;
                        end
                        4'hA: begin
                            mem_addr_q  <= a;
                            mem_wdata_q <= b;
                            mem_we_q    <= 1'b1;
                            state_q     <= MEM_WR;
                        end
                        4'hF: begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                        default: ;
                    endcase
                end
                MEM_RD: begin
                    regs_q[ld_rd_q] <= mem_rdata;
                    result_q        <= mem_rdata;
                    result_reg_q    <= ld_rd_q;
                    result_valid_q  <= 1'b1;
                    state_q         <= IDLE;
                end
                MEM_WR:  state_q <= IDLE;
                default: state_q <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_epw22_cpu.sv
// Directed bench for epw22_cpu: driver tasks push expected write-backs and memory
// writes into queues; a negedge monitor pops and compares whenever the DUT emits one.
module tb_epw22_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        result_valid;
    logic [15:0] result;
    logic [2:0]  result_reg;
    logic [3:0]  flags;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        halted;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    logic [18:0] exp_q[$];   // {reg, value}
    logic [31:0] mem_q[$];   // {addr, wdata}
    logic [18:0] exp_e;
    logic [31:0] mem_e;
    logic [15:0] tb_mem [256];
    int          waits;

    epw22_cpu dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .result_valid(result_valid), .result(result),
        .result_reg(result_reg), .flags(flags), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .halted(halted), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;

    always @(negedge clk) begin
        if (result_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got r%0d=%h, required no write-back", result_reg, result);
            end else begin
                exp_e = exp_q.pop_front();
                if ({result_reg, result} !== exp_e) begin
                    fails++;
                    $display("FAIL wb: got r%0d=%h, required r%0d=%h",
                             result_reg, result, exp_e[18:16], exp_e[15:0]);
                end
            end
        end
        if (mem_we) begin
            tests++;
            if (mem_q.size() == 0) begin
                fails++;
                $display("FAIL mem_unexpected: got [%h]=%h, required no write", mem_addr, mem_wdata);
            end else begin
                mem_e = mem_q.pop_front();
                if ({mem_addr, mem_wdata} !== mem_e) begin
                    fails++;
                    $display("FAIL mem: got [%h]=%h, required [%h]=%h",
                             mem_addr, mem_wdata, mem_e[31:16], mem_e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [2:0] r, input logic [15:0] v);
        exp_q.push_back({r, v});
    endtask

    // Returns with the instruction accepted; time is 1 unit after the accepting edge.
    task automatic issue(input logic [15:0] w, output int stalls);
        stalls = 0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && stalls < 20) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (stalls >= 20) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: instr %h not accepted after %0d cycles, required acceptance", w, stalls);
            instr_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("abort_mem_we", mem_we, 0);
        chk("abort_ready", instr_ready, 0);
        chk("abort_result_valid", result_valid, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_ready", instr_ready, 1);
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        #2;
        chk("rst_ready", instr_ready, 0);
        chk("rst_flags", flags, 0);
        chk("rst_result", {result_reg, result}, 0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_halted", halted, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_ready", instr_ready, 1);

        // LDI leaves flags alone
        expect_wb(1, 16'h0005); issue(16'h8205, waits);
        expect_wb(2, 16'hFFFD); issue(16'h85FD, waits);
        chk("ldi_flags", flags, 4'b0000);

        // Build r1=0x7FFF, then signed overflow on ADD and zero on SUB
        expect_wb(1, 16'hFFFF); issue(16'h83FF, waits);
        expect_wb(6, 16'h0001); issue(16'h8C01, waits);
        expect_wb(1, 16'h7FFF); issue(16'h7270, waits);
        chk("shr_flags", flags, 4'b0000);
        expect_wb(2, 16'h0001); issue(16'h8401, waits);
        expect_wb(3, 16'h8000); issue(16'h1650, waits);
        chk("add_ovf_flags", flags, 4'b0101);
        expect_wb(4, 16'h0000); issue(16'h2848, waits);
        chk("sub_zero_flags", flags, 4'b1000);

        // CMP 2-3 borrows and goes negative, no write-back
        expect_wb(1, 16'h0002); issue(16'h8202, waits);
        expect_wb(2, 16'h0003); issue(16'h8403, waits);
        issue(16'hE050, waits);
        chk("cmp_no_wb", result_valid, 0);
        chk("cmp_flags", flags, 4'b0110);
        expect_wb(6, 16'h0004); issue(16'h8C04, waits);
        expect_wb(5, 16'h0020); issue(16'h6A70, waits);
        chk("shl_flags", flags, 4'b0000);

        // r7=0x0010, r1=0xABCD, then ST and LD round trip
        expect_wb(7, 16'h0010); issue(16'h8E10, waits);
        expect_wb(1, 16'h00AB); issue(16'h82AB, waits);
        expect_wb(6, 16'h0008); issue(16'h8C08, waits);
        expect_wb(1, 16'hAB00); issue(16'h6270, waits);
        expect_wb(2, 16'h00CD); issue(16'h84CD, waits);
        expect_wb(1, 16'hABCD); issue(16'h4250, waits);
        chk("or_flags", flags, 4'b0100);
        mem_q.push_back({16'h0010, 16'hABCD});
        issue(16'hA1C8, waits);
        chk("st_we_high", mem_we, 1);
        chk("st_ready_low", instr_ready, 0);
        chk("st_flags_kept", flags, 4'b0100);
        expect_wb(2, 16'hABCD); issue(16'h95C0, waits);
        chk("ld_after_st_stall", waits, 1);
        chk("ld_ready_low", instr_ready, 0);
        chk("ld_no_early_wb", result_valid, 0);
        @(posedge clk); #1;
        chk("ld_wb_cycle2", result_valid, 1);
        chk("ld_ready_back", instr_ready, 1);

        // Back-to-back ALU with valid held, then a held instruction behind LD
        expect_wb(3, 16'h8001); issue(16'hD6C0, waits);
        chk("b2b_inc_stall", waits, 0);
        expect_wb(4, 16'h8001); issue(16'hB8C0, waits);
        chk("b2b_mov_stall", waits, 0);
        chk("b2b_mov_valid", result_valid, 1);
        expect_wb(5, 16'h7FFE); issue(16'hCB00, waits);
        chk("b2b_not_valid", result_valid, 1);
        expect_wb(6, 16'hFFFF); issue(16'h5D60, waits);
        chk("b2b_xor_valid", result_valid, 1);
        expect_wb(0, 16'h8001); issue(16'h3198, waits);
        chk("b2b_and_stall", waits, 0);
        chk("and_flags", flags, 4'b0100);
        expect_wb(1, 16'hABCD); issue(16'h93C0, waits);
        expect_wb(2, 16'h579A); issue(16'h1448, waits);
        chk("held_after_ld_stall", waits, 1);
        chk("add_carry_flags", flags, 4'b0011);

        @(negedge clk); @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        // Reset mid-LD, then mid-ST: nothing may complete
        issue(16'h97C0, waits);
        pulse_reset();
        chk("post_rst_flags", flags, 0);
        expect_wb(7, 16'h0010); issue(16'h8E10, waits);
        issue(16'hA1C8, waits);
        pulse_reset();
        chk("st_aborted_mem", tb_mem[16], 16'hABCD);
        expect_wb(7, 16'h0000); issue(16'hBFC0, waits);
        expect_wb(2, 16'h0000); issue(16'h1458, waits);
        chk("zero_regs_flags", flags, 4'b1000);

        // HALT: ready stays low with a held instruction
        issue(16'hF000, waits);
        chk("halted", halted, 1);
        instr = 16'h8205;
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("halt_ready_low", instr_ready, 0);
        end
        chk("halt_still", halted, 1);
        instr_valid = 1'b0;

        @(negedge clk); @(negedge clk);
        chk("final_wb_queue", exp_q.size(), 0);
        chk("final_mem_queue", mem_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
